// File: rtl/rng_pkg.sv
// Shared definitions for the random-word packer.
//   RNG_WORD_W / RNG_FIFO_DEPTH : default word width and FIFO depth
//   pair_e                      : von Neumann pair state
//   vn_decode(a,b)              : returns {keep, bit} for a bit pair
package rng_pkg;

   localparam int RNG_WORD_W     = 8;
   localparam int RNG_FIFO_DEPTH = 4;

   typedef enum logic {
      PAIR_EMPTY = 1'b0,
      PAIR_HALF  = 1'b1
   } pair_e;

   // 01 -> keep 0, 10 -> keep 1, 00/11 -> discard.
   // For an unequal pair the kept bit equals the first bit.
   function automatic logic [1:0] vn_decode(input logic a, input logic b);
      return {a ^ b, a};
   endfunction

endpackage

// File: rtl/rng_word_fifo.sv
// Synchronous circular FIFO for packed words.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous empty, wins over push/pop
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head word (register contents at read pointer)
//   level      : stored word count; full / empty flags
module rng_word_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a full FIFO still takes a word when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rnd_word_packer.sv
// Packs a serial random-bit stream (optionally von Neumann debiased) into
// WORD_W-bit words, MSB first, buffered in a FIFO and gated by the health flag.
//   bit_in/bit_valid : serial input bits
//   health_ok        : 1 = health tests passing; 0 wipes buffered data
//   debias_en        : 1 = von Neumann mode, 0 = raw
//   flush            : synchronous clear of buffers and sticky flags
//   word_out/word_valid/word_ready : output handshake (word_out 0 when idle)
//   fifo_level       : stored word count
//   overflow         : sticky, a completed word was dropped
//   health_block     : sticky, a health failure was seen since last flush
module rnd_word_packer
   import rng_pkg::*;
#(
   parameter int WORD_W     = RNG_WORD_W,
   parameter int FIFO_DEPTH = RNG_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          bit_in,
   input  logic                          bit_valid,
   input  logic                          health_ok,
   input  logic                          debias_en,
   input  logic                          flush,
   output logic [WORD_W-1:0]             word_out,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          health_block
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam int SH_W  = WORD_W - 1;

   pair_e             pair_state;
   logic              pair_bit;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SH_W-1:0]   shreg;      // first WORD_W-1 bits of the word in progress
   logic              debias_q;

   logic              mode_chg;
   logic              offered;
   logic [1:0]        vn;
   logic              acc;
   logic              acc_bit;
   logic              word_done;
   logic              push;
   logic              pop;
   logic              clr;
   logic              full;
   logic              empty;
   logic [WORD_W-1:0] head;

   assign mode_chg = (debias_en != debias_q);
   // a bit arriving on a mode switch is dropped along with the partial state
   assign offered  = bit_valid & health_ok & ~health_block & ~flush & ~mode_chg;
   assign vn       = vn_decode(pair_bit, bit_in);

   always_comb begin
      acc     = 1'b0;
      acc_bit = bit_in;
      if (offered) begin
         if (!debias_en) begin
            acc = 1'b1;
         end else if (pair_state == PAIR_HALF) begin
            acc     = vn[1];
            acc_bit = vn[0];
         end
      end
   end

   assign word_done  = acc & (bit_cnt == CNT_W'(WORD_W - 1));
   assign word_valid = ~empty & ~health_block;
   assign pop        = word_valid & word_ready;
   assign push       = word_done & (~full | pop);
   assign clr        = flush | ~health_ok;
   assign word_out   = word_valid ? head : '0;

   rng_word_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr),
      .push  (push),
      .din   ({shreg, acc_bit}),
      .pop   (pop),
      .dout  (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_state   <= PAIR_EMPTY;
         pair_bit     <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         debias_q     <= 1'b0;
         overflow     <= 1'b0;
         health_block <= 1'b0;
      end else begin
         debias_q <= debias_en;
         if (flush || !health_ok || mode_chg) begin
            pair_state <= PAIR_EMPTY;
            bit_cnt    <= '0;
            shreg      <= '0;
            if (flush) begin
               overflow     <= 1'b0;
               health_block <= ~health_ok;
            end else if (!health_ok) begin
               health_block <= 1'b1;
            end
         end else begin
            if (offered && debias_en) begin
               if (pair_state == PAIR_EMPTY) begin
                  pair_state <= PAIR_HALF;
                  pair_bit   <= bit_in;
               end else begin
                  pair_state <= PAIR_EMPTY;
               end
            end
            if (acc) begin
               shreg   <= SH_W'({shreg, acc_bit});
               bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            // dropped word still restarts the packer at bit 0
            if (word_done && full && !pop) overflow <= 1'b1;
         end
      end
   end

endmodule
